// File: rtl/weight_writeback.sv
// Burst write-back of processor result words into the shared single-port RAM behind the ROM read path.
// Optional feature macro: WEIGHT_WRITEBACK_CHECKSUM_EN adds a running checksum output.

// Generic synchronous FIFO with the head word always visible on head_dat_o.
// Latency: a word pushed at edge N is visible at the head from edge N onward.
// Backpressure: caller must not push when full_o is high nor pop when empty_o is high.
module weight_writeback_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_dat_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat_i;
    end
endmodule

// Accepts len words on a valid/ready stream and writes them to consecutive RAM addresses from base_addr.
// Latency: a word accepted at edge N is popped at N+1 and driven on wr_* until the RAM writes it at N+2.
// Backpressure: in_ready drops when the FIFO is full or len words are in; ram_grant low stalls writes.
module weight_writeback #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ram_grant,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
    , output logic [DATA_W-1:0] checksum
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   len_q,      len_d;
    logic [ADDR_W:0]   acc_cnt_q,  acc_cnt_d;
    logic [ADDR_W:0]   wr_rem_q,   wr_rem_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;

    // in_ready deliberately ignores a same-cycle pop so it depends on registered state only.
    assign in_ready = (state_q == S_WRITE) && !fifo_full && (acc_cnt_q < len_q);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_WRITE) && !fifo_empty && ram_grant;

    weight_writeback_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (in_data),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        acc_cnt_d  = acc_cnt_q;
        wr_rem_d   = wr_rem_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d = base_addr;
                    len_d      = len;
                    acc_cnt_d  = '0;
                    wr_rem_d   = len;
                    state_d    = (len == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (push) acc_cnt_d = acc_cnt_q + CNT_ONE;
                if (pop) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = cur_addr_q;
                    wr_data_d  = fifo_head;
                    cur_addr_d = cur_addr_q + ADDR_ONE;
                    wr_rem_d   = wr_rem_q - CNT_ONE;
                    if (wr_rem_q == CNT_ONE) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            wr_rem_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_rem_q   <= wr_rem_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Accumulates alongside the wr_data register so it moves in the same cycle as wr_en.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) checksum_d = '0;
        else if (pop)                   checksum_d = checksum_q + fifo_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_weight_writeback.sv
// Directed bench for weight_writeback: burst, stall, wrap, zero length and mid-burst reset.
module tb_weight_writeback;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_grant;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    weight_writeback #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_grant (ram_grant),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
        , .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int chk_total = 0;
    int chk_pass  = 0;

    // Write log captured at the falling edge, when wr_* are stable.
    logic [ADDR_W-1:0] log_addr [$];
    logic [DATA_W-1:0] log_data [$];
    int                log_cyc  [$];
    int                done_cnt = 0;
    logic              done_wr_en;
    logic [ADDR_W-1:0] done_addr;
    logic [DATA_W-1:0] done_chk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            log_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt   = done_cnt + 1;
            done_wr_en = wr_en;
            done_addr  = wr_addr;
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
            done_chk   = checksum;
`else
            done_chk   = '0;
`endif
        end
    end

    logic [DATA_W-1:0] words [8];
    int                k;
    int                first_acc;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt = 0;
    endtask

    // One cycle of producer activity: offer the next word, count it if it is taken.
    task automatic drive_cycle(input int n);
        in_valid = 1'b1;
        in_data  = (k < n) ? words[k] : 32'hBAD0_BAD0;
        #1;
        if (in_valid && in_ready) begin
            if (k == 0) first_acc = cyc + 1;
            k = k + 1;
        end
        tick();
    endtask

    task automatic begin_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n);
        clear_log();
        k         = 0;
        start     = 1'b1;
        base_addr = base;
        len       = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        chk_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else chk_pass++;
        chk_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else chk_pass++;
        chk_total++; if (wr_addr !== 11'h000) $display("FAIL reset_wr_addr: got %h want 000", wr_addr); else chk_pass++;
        chk_total++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else chk_pass++;
        chk_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else chk_pass++;
        chk_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else chk_pass++;
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
        chk_total++; if (checksum !== 32'h0) $display("FAIL reset_checksum: got %h want 0", checksum); else chk_pass++;
`endif
        rst = 1'b0;
        tick();
        chk_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else chk_pass++;
    endtask

    task automatic test_basic_burst();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a    = '{11'h010, 11'h011, 11'h012, 11'h013};
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;
        ram_grant = 1'b1;
        clear_log();
        k         = 0;
        start     = 1'b1;
        base_addr = 11'h010;
        len       = 12'd4;
        in_valid  = 1'b1;
        in_data   = words[0];
        #1;
        chk_total++; if (in_ready !== 1'b0) $display("FAIL basic_start_ready: got %b want 0", in_ready); else chk_pass++;
        tick();
        start = 1'b0;
        chk_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else chk_pass++;
        for (int c = 0; c < 40 && done_cnt == 0; c++) drive_cycle(4);
        chk_total++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else chk_pass++;
        chk_total++; if (k !== 4) $display("FAIL basic_accepts: got %0d want 4", k); else chk_pass++;
        chk_total++; if (log_addr.size() !== 4) $display("FAIL basic_writes: got %0d want 4", log_addr.size()); else chk_pass++;
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk_total++; if (log_addr[i] !== exp_a[i]) $display("FAIL basic_addr[%0d]: got %h want %h", i, log_addr[i], exp_a[i]); else chk_pass++;
            chk_total++; if (log_data[i] !== words[i]) $display("FAIL basic_data[%0d]: got %h want %h", i, log_data[i], words[i]); else chk_pass++;
            chk_total++; if (log_cyc[i] !== first_acc + 1 + i) $display("FAIL basic_wr_cycle[%0d]: got %0d want %0d", i, log_cyc[i], first_acc + 1 + i); else chk_pass++;
        end
        chk_total++; if (done_wr_en !== 1'b1) $display("FAIL basic_done_with_wr: got %b want 1", done_wr_en); else chk_pass++;
        chk_total++; if (done_addr !== 11'h013) $display("FAIL basic_done_addr: got %h want 013", done_addr); else chk_pass++;
`ifdef WEIGHT_WRITEBACK_CHECKSUM_EN
        chk_total++; if (done_chk !== 32'hAAAA_AAAA) $display("FAIL checksum_done: got %h want aaaaaaaa", done_chk); else chk_pass++;
`endif
        in_valid = 1'b0;
        tick();
        chk_total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else chk_pass++;
        chk_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else chk_pass++;
    endtask

    task automatic test_stall();
        logic [ADDR_W-1:0] exp_a;
        for (int i = 0; i < 8; i++) words[i] = 32'hA000_0000 + 32'(i * 17);
        ram_grant = 1'b0;
        in_valid  = 1'b0;
        begin_burst(11'h200, 12'd8);
        for (int c = 0; c < 10; c++) begin
            // A start while busy must not retarget the burst.
            start = (c == 5);
            if (c == 5) begin
                base_addr = 11'h000;
                len       = 12'd1;
            end
            drive_cycle(8);
        end
        start = 1'b0;
        chk_total++; if (k !== 4) $display("FAIL stall_accepts: got %0d want 4", k); else chk_pass++;
        chk_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else chk_pass++;
        chk_total++; if (log_addr.size() !== 0) $display("FAIL stall_no_write: got %0d want 0", log_addr.size()); else chk_pass++;
        ram_grant = 1'b1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) drive_cycle(8);
        in_valid = 1'b0;
        chk_total++; if (k !== 8) $display("FAIL stall_total_accepts: got %0d want 8", k); else chk_pass++;
        chk_total++; if (log_addr.size() !== 8) $display("FAIL stall_writes: got %0d want 8", log_addr.size()); else chk_pass++;
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            exp_a = 11'h200 + 11'(i);
            chk_total++; if (log_addr[i] !== exp_a) $display("FAIL stall_addr[%0d]: got %h want %h", i, log_addr[i], exp_a); else chk_pass++;
            chk_total++; if (log_data[i] !== words[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, log_data[i], words[i]); else chk_pass++;
        end
        chk_total++; if (done_addr !== 11'h207) $display("FAIL stall_done_addr: got %h want 207", done_addr); else chk_pass++;
        tick();
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a    = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        words[0] = 32'h0000_0001;
        words[1] = 32'hFFFF_FFFF;
        words[2] = 32'h1234_5678;
        words[3] = 32'h8765_4321;
        ram_grant = 1'b1;
        in_valid  = 1'b0;
        begin_burst(11'h7FE, 12'd4);
        for (int c = 0; c < 40 && done_cnt == 0; c++) drive_cycle(4);
        in_valid = 1'b0;
        chk_total++; if (log_addr.size() !== 4) $display("FAIL wrap_writes: got %0d want 4", log_addr.size()); else chk_pass++;
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk_total++; if (log_addr[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, log_addr[i], exp_a[i]); else chk_pass++;
            chk_total++; if (log_data[i] !== words[i]) $display("FAIL wrap_data[%0d]: got %h want %h", i, log_data[i], words[i]); else chk_pass++;
        end
        tick();
    endtask

    task automatic test_zero_len();
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        begin_burst(11'h055, 12'd0);
        chk_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else chk_pass++;
        chk_total++; if (in_ready !== 1'b0) $display("FAIL zero_in_ready: got %b want 0", in_ready); else chk_pass++;
        tick();
        chk_total++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else chk_pass++;
        chk_total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else chk_pass++;
        tick();
        tick();
        chk_total++; if (log_addr.size() !== 0) $display("FAIL zero_no_write: got %0d want 0", log_addr.size()); else chk_pass++;
        chk_total++; if (done_cnt !== 1) $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); else chk_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 6; i++) words[i] = 32'hC0DE_0000 + 32'(i);
        ram_grant = 1'b1;
        in_valid  = 1'b0;
        begin_burst(11'h300, 12'd6);
        for (int c = 0; c < 30 && log_addr.size() < 3; c++) drive_cycle(6);
        chk_total++; if (log_addr.size() !== 3) $display("FAIL mid_pre_writes: got %0d want 3", log_addr.size()); else chk_pass++;
        rst = 1'b1;
        #1;
        chk_total++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b want 0", wr_en); else chk_pass++;
        chk_total++; if (wr_addr !== 11'h000) $display("FAIL mid_wr_addr: got %h want 000", wr_addr); else chk_pass++;
        chk_total++; if (wr_data !== 32'h0) $display("FAIL mid_wr_data: got %h want 0", wr_data); else chk_pass++;
        chk_total++; if ({in_ready, busy, done} !== 3'b000) $display("FAIL mid_ctrl: got %b want 000", {in_ready, busy, done}); else chk_pass++;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            tick();
        end
        chk_total++; if (log_addr.size() !== 3) $display("FAIL mid_no_more_writes: got %0d want 3", log_addr.size()); else chk_pass++;
        in_valid = 1'b0;
        words[0] = 32'hDEAD_BEEF;
        begin_burst(11'h100, 12'd1);
        for (int c = 0; c < 20 && done_cnt == 0; c++) drive_cycle(1);
        in_valid = 1'b0;
        tick();
        chk_total++; if (log_addr.size() !== 1) $display("FAIL mid_new_writes: got %0d want 1", log_addr.size()); else chk_pass++;
        if (log_addr.size() > 0) begin
            chk_total++; if (log_addr[0] !== 11'h100) $display("FAIL mid_new_addr: got %h want 100", log_addr[0]); else chk_pass++;
            chk_total++; if (log_data[0] !== 32'hDEAD_BEEF) $display("FAIL mid_new_data: got %h want deadbeef", log_data[0]); else chk_pass++;
        end
        chk_total++; if (done_cnt !== 1) $display("FAIL mid_new_done: got %0d want 1", done_cnt); else chk_pass++;
    endtask

    initial begin
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        ram_grant = 1'b0;
        k         = 0;
        first_acc = 0;
        test_reset();
        test_basic_burst();
        test_stall();
        test_wrap();
        test_zero_len();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule

// File: doc/weight_writeback.md
Name: weight_writeback

Overview:
- Write-side counterpart to the processor's ROM read path. The processor reads with an 11-bit address, 32-bit data and one-cycle synchronous read latency.
- Accepts a burst of 32-bit result/weight words from the neural processor over a valid/ready stream.
- Buffers the words in a small FIFO and writes them to a single-port RAM at consecutive addresses, starting from a base address.
- Writes only when the RAM port arbiter grants the port, so the processor's read traffic on the shared port is never disturbed.

Parameters:
- ADDR_W, 11, RAM address width; matches the romBlock address space.
- DATA_W, 32, word width.
- FIFO_DEPTH, 4, number of buffer entries; power of two, ≥2.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, reset; asynchronous, active-high.
- start, input, 1, one-cycle pulse that begins a burst; sampled only in IDLE.
- base_addr, input, ADDR_W, first RAM address of the burst; latched on start.
- len, input, ADDR_W+1, number of words in the burst; latched on start. Legal range is 0..2^ADDR_W.
- in_valid, input, 1, producer has a word on in_data.
- in_data, input, DATA_W, word to write.
- in_ready, output, 1, block accepts in_data this cycle.
- ram_grant, input, 1, arbiter grants the RAM port this cycle.
- wr_en, output, 1, RAM write enable; registered.
- wr_addr, output, ADDR_W, RAM write address; registered.
- wr_data, output, DATA_W, RAM write data; registered.
- busy, output, 1, burst in progress.
- done, output, 1, one-cycle pulse when the last word has been written.

Behaviour:
- Reset (async assert):
  - State goes to IDLE; FIFO is emptied.
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - Internal counters cleared.
  - Reset mid-burst discards buffered words and issues no further writes.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On start with len≠0: latch base_addr into cur_addr and len into remaining-accept and remaining-write counters; go to WRITE; busy=1 from the next cycle.
  - On start with len=0: go to DONE directly; no writes.
  - start with in_valid asserted in the same cycle: no word is accepted that cycle.
- WRITE:
  - in_ready = (FIFO not full) && (accept count < len). Combinational from registered state; it does not look ahead to a simultaneous pop.
  - Push: on in_valid && in_ready, the word enters the FIFO and the accept count increments.
  - Pop: when the FIFO is non-empty && ram_grant:
    - pop the head;
    - the next cycle drives wr_en=1, wr_addr=cur_addr, wr_data=head;
    - cur_addr increments modulo 2^ADDR_W (0x7FF wraps to 0x000);
    - the write count decrements.
  - Otherwise wr_en=0 the next cycle; wr_addr and wr_data hold their last values.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - ram_grant low stalls writes. The FIFO fills, then in_ready drops. No word is lost or duplicated.
  - Minimum latency: word accepted at edge N, earliest wr_en at edge N+2 (edge N+1 pops, edge N+2 writes).
  - When the last word's pop is registered (write count reaches 0): go to DONE.
- DONE:
  - done=1 for exactly one cycle, coincident with the final wr_en cycle.
  - For len=0, done is asserted the cycle after start.
  - Next state is IDLE; busy=0 in IDLE.
- start while busy is ignored.
- Extra in_valid after len words have been accepted is not accepted (in_ready=0).
- busy=1 in WRITE and DONE.

Optional Feature:
- Macro WEIGHT_WRITEBACK_CHECKSUM_EN.
- When defined:
  - adds output checksum, DATA_W bits;
  - checksum is the running modulo-2^DATA_W sum of every wr_data written in the current burst;
  - cleared to 0 on reset and on an accepted start;
  - updates in the same cycle as wr_en;
  - final value is valid when done is high and holds until the next start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Basic burst:
  - stimulus: rst pulse; start with base_addr=0x010, len=4; words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back; ram_grant=1;
  - response: writes to 0x010..0x013 in order; first wr_en 2 cycles after the first accept; done coincides with the 0x013 write; busy drops after.
- Stall:
  - stimulus: len=8; ram_grant=0 for 10 cycles, then 1;
  - response: in_ready drops after 4 accepts; all 8 words are written to consecutive addresses with no loss or duplicate.
- Wrap:
  - stimulus: base_addr=0x7FE, len=4;
  - response: writes go to 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length:
  - stimulus: start with len=0;
  - response: no wr_en; done one cycle after start; in_ready stays 0.
- Reset mid-burst:
  - stimulus: len=6; assert rst after 3 writes;
  - response: all outputs read 0 immediately; no further wr_en.
  - stimulus: a new start with len=1, data 0xDEADBEEF, base 0x100;
  - response: exactly one write of 0xDEADBEEF to 0x100.
- Checksum (macro defined):
  - stimulus: the basic-burst words;
  - response: checksum=0xAAAAAAAA at done.
